idelay_stepper: RTL

Downstream consumer of the IDELAY scanner's tap-write port (hw_addr/hw_data/hw_strobe). Queues absolute tap requests for up to 16 input lanes and converts each into a paced train of per-lane IDELAY CE/INC increment or decrement pulses. It keeps a shadow copy of every lane's current tap and reports completion. It sits between the scanner (or host) and the IDELAY primitives in VARIABLE mode.

---
 rtl/idelay_stepper.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/idelay_stepper.sv
// Queues absolute IDELAY tap requests for 16 lanes and walks each lane to its
// target with paced CE/INC pulses, keeping a shadow copy of every lane's tap.
module idelay_stepper #(
  parameter int TAP_GAP = 4,
  parameter int FIFO_AW = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  hw_addr,
  input  logic [4:0]  hw_data,
  input  logic        hw_strobe,
  output logic [15:0] idelay_ce,
  output logic        idelay_inc,
  output logic        busy,
  output logic        done_strobe,
  output logic        overflow,
  input  logic        clear_ovf,
  input  logic [3:0]  rd_addr,
  output logic [4:0]  rd_tap
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int GW    = (TAP_GAP > 1) ? $clog2(TAP_GAP) : 1;
  localparam logic [GW-1:0]    GAP_LAST = GW'(TAP_GAP - 1);
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STEP, S_GAP} state_e;

  typedef struct packed {
    logic [3:0] lane;
    logic [4:0] tap;
  } req_t;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  req_t               fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               fifo_empty, fifo_full;
  logic               push, pop, drop;
  req_t               head;

  state_e state_q, state_d;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push       = hw_strobe && (!fifo_full || pop);
  assign drop       = hw_strobe && !push;
  assign head       = fifo_mem[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours regardless of statement order.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the pointers and count alone
  // define which entries are valid, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= '{lane: hw_addr, tap: hw_data};
  end

  // ---------------------------------------------------------------------------
  // Stepping FSM
  // ---------------------------------------------------------------------------
  logic [3:0]    lane_q, lane_d;
  logic [4:0]    target_q, target_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0]   ce_q, ce_d;
  logic          inc_q, inc_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          shadow_we;
  logic [4:0]    shadow_q [16];
  logic [4:0]    cur_tap, shadow_nxt;
  logic [4:0]    rd_tap_q;

  assign cur_tap    = shadow_q[lane_q];
  assign shadow_nxt = inc_q ? cur_tap + 5'd1 : cur_tap - 5'd1;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d   = state_q;
    lane_d    = lane_q;
    target_d  = target_q;
    gap_d     = gap_q;
    ce_d      = '0;
    inc_d     = 1'b0;
    done_d    = 1'b0;
    shadow_we = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          lane_d   = head.lane;
          target_d = head.tap;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (target_q == cur_tap) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          ce_d    = 16'd1 << lane_q;
          inc_d   = (target_q > cur_tap);
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        shadow_we = 1'b1;
        gap_d     = GAP_LAST;
        state_d   = S_GAP;
      end
      S_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else if (cur_tap == target_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          ce_d    = 16'd1 << lane_q;
          inc_d   = (target_q > cur_tap);
          state_d = S_STEP;
        end
      end
    endcase
  end

  // Drop beats clear when both land in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (drop)           ovf_d = 1'b1;
    else if (clear_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lane_q   <= '0;
      target_q <= '0;
      gap_q    <= '0;
      ce_q     <= '0;
      inc_q    <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      target_q <= target_d;
      gap_q    <= gap_d;
      ce_q     <= ce_d;
      inc_q    <= inc_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  // Shadow taps mirror the IDELAYs, which share this reset and restart at 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) shadow_q[i] <= '0;
      rd_tap_q <= '0;
    end else begin
      if (shadow_we) shadow_q[lane_q] <= shadow_nxt;
      rd_tap_q <= shadow_q[rd_addr];
    end
  end

  assign idelay_ce   = ce_q;
  assign idelay_inc  = inc_q;
  assign done_strobe = done_q;
  assign overflow    = ovf_q;
  assign rd_tap      = rd_tap_q;
  assign busy        = !fifo_empty || (state_q != S_IDLE);

`ifndef SYNTHESIS
  a_ce_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(idelay_ce));
  a_no_wrap : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_STEP) |-> (inc_q ? (cur_tap != 5'd31) : (cur_tap != 5'd0)));
  a_done_quiet : assert property (@(posedge clk) disable iff (!rst_n)
    done_strobe |-> (idelay_ce == '0));
`endif

endmodule
